// File: rtl/ccff_loader_if.sv
// Byte-stream side of the ccff loader: write bytes toward the fabric chain and
// the readback bytes captured from its tail.
interface ccff_loader_if;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid;

  modport master (
    output wr_data,
    output wr_valid,
    input  wr_ready,
    input  rd_data,
    input  rd_valid
  );

  modport slave (
    input  wr_data,
    input  wr_valid,
    output wr_ready,
    output rd_data,
    output rd_valid
  );
endinterface

// File: rtl/ccff_loader.sv
// Streams configuration bytes MSB-first into a fabric ccff chain through a gated
// prog_clk and returns the bits shifted out of the chain tail as readback bytes.
module ccff_loader #(
  parameter  int CHAIN_LEN = 128,
  localparam int CW        = $clog2(CHAIN_LEN + 1)
) (
  input  logic          prog_clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  ccff_loader_if.slave  bus,
  output logic          ccff_head,
  input  logic          ccff_tail,
  output logic          shift_en,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] bit_count
);

  localparam logic [CW-1:0] LEN = CW'(CHAIN_LEN);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DATA,
    SHIFT,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [7:0]    shift_reg;
  logic [7:0]    rb_reg;
  logic [7:0]    rb_next;
  logic [7:0]    rd_data_r;
  logic          rd_valid_r;
  logic          done_r;
  logic [2:0]    bit_idx;
  logic [CW-1:0] count_inc;
  logic          pass_end;
  logic          byte_end;
  logic          start_ok;
  logic          accept;
  logic          shifting;
  logic          wr_ready_c;
  logic          busy_c;

  assign count_inc = bit_count + CW'(1);
  assign pass_end  = (count_inc == LEN);
  assign byte_end  = (bit_idx == 3'd7) || pass_end;
  assign rb_next   = {rb_reg[6:0], ccff_tail};

  always_ff @(posedge prog_clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Abort takes priority everywhere: it blocks a start in IDLE, and while busy it
  // suppresses both the byte accept and the gated shift edge of that cycle.
  always_comb begin
    state_nxt  = state;
    start_ok   = 1'b0;
    accept     = 1'b0;
    shifting   = 1'b0;
    wr_ready_c = 1'b0;
    busy_c     = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          start_ok  = 1'b1;
          state_nxt = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        busy_c = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          wr_ready_c = 1'b1;
          if (bus.wr_valid) begin
            accept    = 1'b1;
            state_nxt = SHIFT;
          end
        end
      end
      SHIFT: begin
        busy_c = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          shifting = 1'b1;
          if (byte_end) begin
            state_nxt = pass_end ? DONE : WAIT_DATA;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign shift_en     = shifting;
  assign ccff_head    = shifting & shift_reg[7];
  assign busy         = busy_c;
  assign done         = done_r;
  assign bus.wr_ready = wr_ready_c;
  assign bus.rd_data  = rd_data_r;
  assign bus.rd_valid = rd_valid_r;

  // A short final byte is left-aligned by shifting out the unused LSB positions.
  always_ff @(posedge prog_clk or negedge reset) begin
    if (!reset) begin
      shift_reg  <= '0;
      rb_reg     <= '0;
      rd_data_r  <= '0;
      rd_valid_r <= 1'b0;
      done_r     <= 1'b0;
      bit_idx    <= '0;
      bit_count  <= '0;
    end else begin
      rd_valid_r <= 1'b0;
      if (start_ok) begin
        done_r    <= 1'b0;
        bit_count <= '0;
      end
      if (accept) begin
        shift_reg <= bus.wr_data;
        bit_idx   <= '0;
        rb_reg    <= '0;
      end
      if (shifting) begin
        shift_reg <= {shift_reg[6:0], 1'b0};
        rb_reg    <= rb_next;
        bit_idx   <= bit_idx + 3'd1;
        if (bit_count != LEN) begin
          bit_count <= count_inc;
        end
        if (byte_end) begin
          rd_valid_r <= 1'b1;
          rd_data_r  <= rb_next << (3'd7 - bit_idx);
        end
        if (pass_end) begin
          done_r <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/ccff_loader.md
CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 128: number of configuration flip-flops in the fabric ccff chain; legal range 1..65535.
REQ-002 SHALL have localparam CW = clog2(CHAIN_LEN+1): width of the bit counter.
REQ-003 SHALL have port prog_clk, input, 1: programming clock; the single clock of the block.
REQ-004 SHALL have port reset, input, 1: reset; asynchronous, active-low.
REQ-005 SHALL have port start, input, 1: single-cycle request to begin a load pass.
REQ-006 SHALL have port abort, input, 1: synchronous cancel of a pass in progress.
REQ-007 SHALL have port wr_data, input, 8: configuration byte; shifted out MSB first.
REQ-008 SHALL have port wr_valid, input, 1: wr_data valid.
REQ-009 SHALL have port wr_ready, output, 1: loader accepts wr_data this cycle.
REQ-010 SHALL have port ccff_head, output, 1: serial data into the fabric chain head.
REQ-011 SHALL have port ccff_tail, input, 1: serial data out of the fabric chain tail.
REQ-012 SHALL have port shift_en, output, 1: fabric prog_clk gate enable; the fabric chain advances only on prog_clk edges where shift_en is 1.
REQ-013 SHALL have port rd_data, output, 8: readback byte captured from ccff_tail, MSB first.
REQ-014 SHALL have port rd_valid, output, 1: one-cycle strobe qualifying rd_data; no backpressure.
REQ-015 SHALL have port busy, output, 1: a pass is in progress.
REQ-016 SHALL have port done, output, 1: sticky pass-complete flag.
REQ-017 SHALL have port bit_count, output, CW: number of bits shifted in the current or last pass.

Function
REQ-018 SHALL implement the states IDLE, WAIT_DATA, SHIFT and DONE.
REQ-019 IDLE: start=1 SHALL clear done, clear bit_count and go to WAIT_DATA; wr_valid SHALL be ignored in IDLE.
REQ-020 WAIT_DATA: wr_ready SHALL be 1; on wr_valid=1, wr_data SHALL load the shift register, the per-byte bit index SHALL be set to 0, and the FSM SHALL go to SHIFT.
REQ-021 wr_ready SHALL be 0 in every state other than WAIT_DATA; the accept latency is 1 cycle; the byte period is 9 cycles (1 accept cycle plus 8 shift cycles).
REQ-022 SHIFT: shift_en SHALL be 1, ccff_head SHALL equal the current shift-register MSB, and each cycle SHALL shift left by one, increment bit_count and sample ccff_tail into the readback register LSB.
REQ-023 SHIFT: after the 8th bit, OR when bit_count reaches CHAIN_LEN, the FSM SHALL go to WAIT_DATA if bits remain, otherwise to DONE.
REQ-024 The final byte SHALL shift only CHAIN_LEN mod 8 MSBs (8 if the remainder is 0); its remaining LSBs SHALL be discarded; the byte count per pass is ceil(CHAIN_LEN/8).
REQ-025 rd_valid SHALL pulse for 1 cycle on the cycle after the 8th readback sample, or after the final sample of the pass; a partial final byte SHALL be left-aligned and zero-padded.
REQ-026 ccff_head SHALL be 0 and shift_en SHALL be 0 outside SHIFT, so exactly CHAIN_LEN gated edges occur per pass.
REQ-027 DONE: done SHALL be 1 and busy SHALL be 0; the FSM SHALL go to IDLE in the same cycle; done SHALL remain 1 until the next accepted start.
REQ-028 busy SHALL be 1 in WAIT_DATA and SHIFT.
REQ-029 start SHALL be ignored while busy=1.
REQ-030 abort=1 while busy SHALL force IDLE on the next edge, with shift_en=0, done unchanged at 0, no rd_valid, and bit_count frozen.
REQ-031 If start and abort are both 1 in IDLE, abort SHALL win and the FSM SHALL stay in IDLE.
REQ-032 bit_count SHALL saturate at CHAIN_LEN and SHALL never wrap.

Reset
REQ-033 reset=0 SHALL immediately, without waiting for a clock edge, force IDLE, shift register 0, readback register 0, ccff_head 0, shift_en 0, wr_ready 0, rd_data 0x00, rd_valid 0, busy 0, done 0 and bit_count 0.
REQ-034 Reset asserted mid-pass SHALL drop shift_en asynchronously; the pass SHALL NOT resume after reset release, and a new start is required.

Verification (CHAIN_LEN=12, fabric modelled as a 12-bit gated shift register)
REQ-035 Chain preloaded 0xFFF; start, then write 0xA5 and 0x3C -> ccff_head = 1,0,1,0,0,1,0,1,0,0,1,1; shift_en high for exactly 12 cycles; rd_data 0xFF then 0xF0; done=1; bit_count=12.
REQ-036 Repeat the REQ-035 pass with writes 0x00 and 0x00 -> readback 0xA5 then 0x30; model chain contents 0x000.
REQ-037 wr_valid held low for 5 cycles in WAIT_DATA -> wr_ready stays 1, shift_en stays 0, bit_count holds at 8.
REQ-038 abort asserted after 5 shifted bits -> IDLE next cycle; bit_count=5; done=0; no further shift_en; second start performs a full 12-bit pass.
REQ-039 reset driven low during SHIFT, between clock edges -> shift_en and busy go 0 with no clock edge; all outputs at reset values; start pulse ignored while busy is asserted.
REQ-040 CHAIN_LEN=1, write 0x80 -> exactly one shift_en cycle; ccff_head=1; rd_data = (tail bit)<<7; done next cycle.
